// File: rtl/simd_bram_sequencer_if.sv
// Command, BRAM-port and PE-lane signals shared by the sequencer and its neighbours.
// The sequencer connects through the slave modport; the control/BRAM/lane side uses master.
interface simd_bram_sequencer_if #(
    parameter int NUM_PE = 4,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int LEN_W  = 16
);
    logic                       start;
    logic [1:0]                 cmd;
    logic [ADDR_W-1:0]          base_addr;
    logic [LEN_W-1:0]           len;
    logic [NUM_PE-1:0]          lane_mask;
    logic                       busy;
    logic                       done;
    logic                       err;
    logic [ADDR_W-1:0]          addrb;
    logic [DATA_W-1:0]          dinb;
    logic [DATA_W-1:0]          doutb;
    logic                       enb;
    logic [DATA_W/8-1:0]        web;
    logic [NUM_PE*DATA_W-1:0]   lane_din;
    logic [NUM_PE-1:0]          lane_wr;
    logic [NUM_PE*DATA_W-1:0]   lane_dout;
    logic [NUM_PE-1:0]          lane_rd;
    logic [NUM_PE-1:0]          lane_ready;

    modport slave (
        input  start, cmd, base_addr, len, lane_mask, doutb, lane_dout, lane_ready,
        output busy, done, err, addrb, dinb, enb, web, lane_din, lane_wr, lane_rd
    );

    modport master (
        output start, cmd, base_addr, len, lane_mask, doutb, lane_dout, lane_ready,
        input  busy, done, err, addrb, dinb, enb, web, lane_din, lane_wr, lane_rd
    );
endinterface

// File: rtl/simd_bram_sequencer.sv
// Load/store sequencer moving words between one BRAM port and NUM_PE PE lanes,
// with lane masking, broadcast loads and a configurable BRAM read latency.
module simd_bram_sequencer #(
    parameter int NUM_PE = 4,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int LEN_W  = 16,
    parameter int RD_LAT = 2
) (
    input  logic                CLK,
    input  logic                RSTN,
    simd_bram_sequencer_if.slave bus
);
    localparam int LANE_W = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;
    localparam int WE_W   = DATA_W / 8;

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_RD_ISSUE = 3'd1;
    localparam logic [2:0] S_RD_DRAIN = 3'd2;
    localparam logic [2:0] S_WR_WAIT  = 3'd3;
    localparam logic [2:0] S_WR       = 3'd4;
    localparam logic [2:0] S_FIN      = 3'd5;

    localparam logic [1:0] CMD_BCAST  = 2'b01;
    localparam logic [1:0] CMD_RSVD   = 2'b11;

    function automatic logic [LANE_W-1:0] firstLane(input logic [NUM_PE-1:0] mask);
        logic [LANE_W-1:0] idx;
        logic              found;
        idx   = '0;
        found = 1'b0;
        for (int k = 0; k < NUM_PE; k++) begin
            if (!found && mask[k]) begin
                idx   = LANE_W'(k);
                found = 1'b1;
            end
        end
        return idx;
    endfunction

    // Next enabled lane above cur, wrapping; a single enabled lane maps to itself.
    function automatic logic [LANE_W-1:0] nextLane(input logic [LANE_W-1:0] cur,
                                                   input logic [NUM_PE-1:0] mask);
        logic [LANE_W-1:0] idx;
        logic              found;
        int                cand;
        idx   = cur;
        found = 1'b0;
        for (int k = 1; k <= NUM_PE; k++) begin
            cand = (int'(cur) + k) % NUM_PE;
            if (!found && mask[cand]) begin
                idx   = LANE_W'(cand);
                found = 1'b1;
            end
        end
        return idx;
    endfunction

    logic [2:0]                r_state;
    logic [1:0]                r_cmd;
    logic [ADDR_W-1:0]         r_addr;
    logic [LEN_W-1:0]          r_cnt;
    logic [NUM_PE-1:0]         r_mask;
    logic [LANE_W-1:0]         r_lane;
    logic                      r_err;
    logic [RD_LAT-1:0]         r_pipeValid;
    logic [LANE_W-1:0]         r_pipeLane [RD_LAT];
    logic [NUM_PE*DATA_W-1:0]  r_laneDin;
    logic [NUM_PE-1:0]         r_laneWr;

    logic                      w_issue;
    logic                      w_write;
    logic                      w_lastWord;
    logic                      w_pipeEmpty;
    logic                      w_retValid;
    logic [LANE_W-1:0]         w_retLane;
    logic [LANE_W-1:0]         w_nextLane;
    logic                      w_startErr;
    logic [DATA_W-1:0]         w_writeData;
    logic [NUM_PE-1:0]         w_laneRd;

    assign w_issue     = (r_state == S_RD_ISSUE);
    assign w_write     = (r_state == S_WR);
    assign w_lastWord  = (r_cnt == LEN_W'(1));
    assign w_pipeEmpty = (r_pipeValid == '0);
    assign w_retValid  = r_pipeValid[RD_LAT-1];
    assign w_retLane   = r_pipeLane[RD_LAT-1];
    assign w_nextLane  = nextLane(r_lane, r_mask);
    assign w_startErr  = (bus.cmd == CMD_RSVD) || (bus.lane_mask == '0);

    always_comb begin
        w_writeData = '0;
        w_laneRd    = '0;
        for (int k = 0; k < NUM_PE; k++) begin
            if (r_lane == LANE_W'(k)) begin
                w_writeData = bus.lane_dout[k*DATA_W +: DATA_W];
                w_laneRd[k] = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            r_state     <= S_IDLE;
            r_cmd       <= '0;
            r_addr      <= '0;
            r_cnt       <= '0;
            r_mask      <= '0;
            r_lane      <= '0;
            r_err       <= 1'b0;
            r_pipeValid <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                r_pipeLane[i] <= '0;
            end
            r_laneDin   <= '0;
            r_laneWr    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_cmd  <= bus.cmd;
                        r_addr <= bus.base_addr;
                        r_cnt  <= bus.len;
                        r_mask <= bus.lane_mask;
                        r_lane <= firstLane(bus.lane_mask);
                        r_err  <= w_startErr;
                        if (w_startErr || (bus.len == '0)) begin
                            r_state <= S_FIN;
                        end else if (bus.cmd[1]) begin
                            r_state <= S_WR_WAIT;
                        end else begin
                            r_state <= S_RD_ISSUE;
                        end
                    end
                end
                S_RD_ISSUE: begin
                    r_addr <= r_addr + ADDR_W'(4);
                    r_cnt  <= r_cnt - LEN_W'(1);
                    r_lane <= w_nextLane;
                    if (w_lastWord) begin
                        r_state <= S_RD_DRAIN;
                    end
                end
                S_RD_DRAIN: begin
                    if (w_pipeEmpty) begin
                        r_state <= S_FIN;
                    end
                end
                S_WR_WAIT: begin
                    if ((bus.lane_ready & r_mask) == r_mask) begin
                        r_state <= S_WR;
                    end
                end
                S_WR: begin
                    r_addr <= r_addr + ADDR_W'(4);
                    r_cnt  <= r_cnt - LEN_W'(1);
                    r_lane <= w_nextLane;
                    if (w_lastWord) begin
                        r_state <= S_FIN;
                    end
                end
                S_FIN: begin
                    r_err   <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase

            // Each issued read carries its target lane down the pipe so it lands when doutb is valid.
            for (int i = RD_LAT - 1; i > 0; i--) begin
                r_pipeValid[i] <= r_pipeValid[i-1];
                r_pipeLane[i]  <= r_pipeLane[i-1];
            end
            r_pipeValid[0] <= w_issue;
            r_pipeLane[0]  <= r_lane;

            r_laneWr <= '0;
            if (w_retValid) begin
                for (int k = 0; k < NUM_PE; k++) begin
                    if ((r_cmd == CMD_BCAST) ? r_mask[k] : (w_retLane == LANE_W'(k))) begin
                        r_laneWr[k]                     <= 1'b1;
                        r_laneDin[k*DATA_W +: DATA_W]   <= bus.doutb;
                    end
                end
            end
        end
    end

    assign bus.busy     = (r_state != S_IDLE) && (r_state != S_FIN);
    assign bus.done     = (r_state == S_FIN);
    assign bus.err      = (r_state == S_FIN) && r_err;
    assign bus.addrb    = r_addr;
    assign bus.enb      = w_issue || w_write;
    assign bus.web      = w_write ? {WE_W{1'b1}} : {WE_W{1'b0}};
    assign bus.dinb     = w_write ? w_writeData : '0;
    assign bus.lane_rd  = w_write ? w_laneRd : '0;
    assign bus.lane_din = r_laneDin;
    assign bus.lane_wr  = r_laneWr;
endmodule

// File: tb/tb_simd_bram_sequencer.sv
// Directed bench for simd_bram_sequencer with a latency-modelled BRAM and popping PE lanes.
module tb_simd_bram_sequencer;
    localparam int NUM_PE = 4;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;
    localparam int LEN_W  = 16;
    localparam int RD_LAT = 2;

    typedef struct { int cyc; logic [31:0] addr; logic [3:0] web; logic [31:0] din; logic [3:0] rd; } enbEv_t;
    typedef struct { int cyc; logic [3:0] wr; logic [NUM_PE*DATA_W-1:0] din; } wrEv_t;
    typedef struct { int cyc; logic err; } doneEv_t;

    logic CLK;
    logic RSTN;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   popCnt [NUM_PE] = '{default: 0};
    logic [31:0] rdPipe [RD_LAT];

    enbEv_t  enbQ[$];
    wrEv_t   wrQ[$];
    doneEv_t doneQ[$];

    simd_bram_sequencer_if #(.NUM_PE(NUM_PE), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .LEN_W(LEN_W)) bus ();

    simd_bram_sequencer #(.NUM_PE(NUM_PE), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .LEN_W(LEN_W), .RD_LAT(RD_LAT)) dut (
        .CLK (CLK),
        .RSTN(RSTN),
        .bus (bus.slave)
    );

    function automatic logic [31:0] memWord(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    function automatic logic [31:0] laneWord(input int k, input int pops);
        return 32'hC0DE_0000 + 32'(k * 16) + 32'(pops);
    endfunction

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    // BRAM: read data appears RD_LAT cycles after the enb cycle
    always @(posedge CLK) begin
        for (int i = RD_LAT - 1; i > 0; i--) rdPipe[i] <= rdPipe[i-1];
        rdPipe[0] <= (bus.enb && bus.web == 4'h0) ? memWord(bus.addrb) : 32'hBAD0_BAD0;
    end
    assign bus.doutb = rdPipe[RD_LAT-1];

    // PE lanes: head value advances after each pop
    always @(posedge CLK) begin
        for (int k = 0; k < NUM_PE; k++) if (bus.lane_rd[k]) popCnt[k] <= popCnt[k] + 1;
    end
    always_comb begin
        bus.lane_dout = '0;
        for (int k = 0; k < NUM_PE; k++) bus.lane_dout[k*DATA_W +: DATA_W] = laneWord(k, popCnt[k]);
    end

    always @(negedge CLK) begin
        if (bus.enb) enbQ.push_back('{cyc, bus.addrb, bus.web, bus.dinb, bus.lane_rd});
        if (bus.lane_wr != '0) wrQ.push_back('{cyc, bus.lane_wr, bus.lane_din});
        if (bus.done) doneQ.push_back('{cyc, bus.err});
    end

    task automatic clearLogs();
        enbQ.delete();
        wrQ.delete();
        doneQ.delete();
    endtask

    task automatic startCmd(input logic [1:0] c, input logic [31:0] base, input logic [15:0] n, input logic [3:0] m);
        @(posedge CLK); #1;
        bus.start = 1'b1; bus.cmd = c; bus.base_addr = base; bus.len = n; bus.lane_mask = m;
        @(posedge CLK); #1;
        bus.start = 1'b0;
    endtask

    task automatic waitDone(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge CLK); #1;
            if (doneQ.size() != 0) break;
        end
        repeat (3) @(negedge CLK);
        #1;
    endtask

    task automatic test_reset();
        RSTN = 1'b0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        checks++;
        if ({bus.busy, bus.done, bus.err, bus.enb, bus.lane_wr, bus.lane_rd, bus.web} !== '0) begin
            errors++; $display("[TB] FAIL reset_ctrl: got %b expected 0", {bus.busy, bus.done, bus.err, bus.enb, bus.lane_wr, bus.lane_rd, bus.web});
        end
        checks++;
        if ({bus.addrb, bus.dinb, bus.lane_din} !== '0) begin
            errors++; $display("[TB] FAIL reset_data: addrb %h dinb %h lane_din %h expected 0", bus.addrb, bus.dinb, bus.lane_din);
        end
        @(posedge CLK); #1;
        RSTN = 1'b1;
    endtask

    task automatic test_interleave();
        int ln;
        clearLogs();
        startCmd(2'b00, 32'h100, 16'd8, 4'b1111);
        waitDone(60);
        checks++;
        if (enbQ.size() !== 8) begin errors++; $display("[TB] FAIL il_enb_count: got %0d expected 8", enbQ.size()); end
        for (int i = 0; i < enbQ.size() && i < 8; i++) begin
            checks++;
            if (enbQ[i].addr !== 32'h100 + 32'(4*i) || enbQ[i].web !== 4'h0 || enbQ[i].cyc !== enbQ[0].cyc + i) begin
                errors++; $display("[TB] FAIL il_issue%0d: addr %h web %h cyc %0d expected addr %h web 0 cyc %0d",
                                   i, enbQ[i].addr, enbQ[i].web, enbQ[i].cyc, 32'h100 + 32'(4*i), enbQ[0].cyc + i);
            end
        end
        checks++;
        if (wrQ.size() !== 8) begin errors++; $display("[TB] FAIL il_wr_count: got %0d expected 8", wrQ.size()); end
        for (int i = 0; i < wrQ.size() && i < 8; i++) begin
            ln = i % 4;
            checks++;
            if (wrQ[i].wr !== 4'(1 << ln) || wrQ[i].din[ln*32 +: 32] !== memWord(32'h100 + 32'(4*i))) begin
                errors++; $display("[TB] FAIL il_word%0d: lane_wr %b data %h expected %b %h",
                                   i, wrQ[i].wr, wrQ[i].din[ln*32 +: 32], 4'(1 << ln), memWord(32'h100 + 32'(4*i)));
            end
        end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (bus.lane_din[k*32 +: 32] !== memWord(32'h110 + 32'(4*k))) begin
                errors++; $display("[TB] FAIL il_final_lane%0d: got %h expected %h", k, bus.lane_din[k*32 +: 32], memWord(32'h110 + 32'(4*k)));
            end
        end
        checks++;
        if (doneQ.size() !== 1 || wrQ.size() == 0 || doneQ[0].err !== 1'b0 || doneQ[0].cyc !== wrQ[wrQ.size()-1].cyc + 1) begin
            errors++; $display("[TB] FAIL il_done: done count %0d expected 1 err 0 one cycle after last lane_wr", doneQ.size());
        end
    endtask

    task automatic test_masked();
        int expLane [4] = '{1, 3, 1, 3};
        clearLogs();
        startCmd(2'b00, 32'h200, 16'd4, 4'b1010);
        waitDone(40);
        checks++;
        if (wrQ.size() !== 4) begin errors++; $display("[TB] FAIL mask_wr_count: got %0d expected 4", wrQ.size()); end
        for (int i = 0; i < wrQ.size() && i < 4; i++) begin
            checks++;
            if (wrQ[i].wr !== 4'(1 << expLane[i]) || wrQ[i].din[expLane[i]*32 +: 32] !== memWord(32'h200 + 32'(4*i))) begin
                errors++; $display("[TB] FAIL mask_word%0d: lane_wr %b data %h expected %b %h", i, wrQ[i].wr,
                                   wrQ[i].din[expLane[i]*32 +: 32], 4'(1 << expLane[i]), memWord(32'h200 + 32'(4*i)));
            end
        end
        checks++;
        if (doneQ.size() !== 1 || doneQ[0].err !== 1'b0) begin errors++; $display("[TB] FAIL mask_done: count %0d expected 1 with err 0", doneQ.size()); end
    endtask

    task automatic test_broadcast();
        clearLogs();
        startCmd(2'b01, 32'h300, 16'd2, 4'b0111);
        waitDone(40);
        checks++;
        if (wrQ.size() !== 2) begin errors++; $display("[TB] FAIL bc_wr_count: got %0d expected 2", wrQ.size()); end
        for (int i = 0; i < wrQ.size() && i < 2; i++) begin
            checks++;
            if (wrQ[i].wr !== 4'b0111) begin errors++; $display("[TB] FAIL bc_strobe%0d: got %b expected 0111", i, wrQ[i].wr); end
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (wrQ[i].din[k*32 +: 32] !== memWord(32'h300 + 32'(4*i))) begin
                    errors++; $display("[TB] FAIL bc_data%0d_lane%0d: got %h expected %h", i, k, wrQ[i].din[k*32 +: 32], memWord(32'h300 + 32'(4*i)));
                end
            end
            checks++;
            if (wrQ[i].din[96 +: 32] !== memWord(32'h20C)) begin
                errors++; $display("[TB] FAIL bc_hold_lane3: got %h expected %h", wrQ[i].din[96 +: 32], memWord(32'h20C));
            end
        end
    endtask

    task automatic test_store();
        int pops [NUM_PE];
        int expLane [4] = '{0, 2, 0, 2};
        clearLogs();
        bus.lane_ready = 4'b0111;
        for (int k = 0; k < NUM_PE; k++) pops[k] = popCnt[k];
        startCmd(2'b10, 32'h400, 16'd4, 4'b1111);
        repeat (5) begin @(posedge CLK); #1; end
        checks++;
        if (enbQ.size() !== 0) begin errors++; $display("[TB] FAIL st_wait_enb: got %0d enb cycles expected 0", enbQ.size()); end
        bus.lane_ready = 4'b1111;
        waitDone(40);
        checks++;
        if (enbQ.size() !== 4) begin errors++; $display("[TB] FAIL st_enb_count: got %0d expected 4", enbQ.size()); end
        for (int i = 0; i < enbQ.size() && i < 4; i++) begin
            checks++;
            if (enbQ[i].addr !== 32'h400 + 32'(4*i) || enbQ[i].web !== 4'hF || enbQ[i].rd !== 4'(1 << i) ||
                enbQ[i].din !== laneWord(i, pops[i])) begin
                errors++; $display("[TB] FAIL st_word%0d: addr %h web %h rd %b din %h expected %h F %b %h", i, enbQ[i].addr,
                                   enbQ[i].web, enbQ[i].rd, enbQ[i].din, 32'h400 + 32'(4*i), 4'(1 << i), laneWord(i, pops[i]));
            end
            pops[i]++;
        end
        checks++;
        if (doneQ.size() !== 1 || enbQ.size() == 0 || doneQ[0].err !== 1'b0 || doneQ[0].cyc !== enbQ[enbQ.size()-1].cyc + 1) begin
            errors++; $display("[TB] FAIL st_done: count %0d expected 1 err 0 right after last write", doneQ.size());
        end
        // masked store rotates 0,2,0,2 and sees each lane's next result
        clearLogs();
        for (int k = 0; k < NUM_PE; k++) pops[k] = popCnt[k];
        startCmd(2'b10, 32'h480, 16'd4, 4'b0101);
        waitDone(40);
        checks++;
        if (enbQ.size() !== 4) begin errors++; $display("[TB] FAIL st2_enb_count: got %0d expected 4", enbQ.size()); end
        for (int i = 0; i < enbQ.size() && i < 4; i++) begin
            checks++;
            if (enbQ[i].rd !== 4'(1 << expLane[i]) || enbQ[i].din !== laneWord(expLane[i], pops[expLane[i]])) begin
                errors++; $display("[TB] FAIL st2_word%0d: rd %b din %h expected %b %h", i, enbQ[i].rd, enbQ[i].din,
                                   4'(1 << expLane[i]), laneWord(expLane[i], pops[expLane[i]]));
            end
            pops[expLane[i]]++;
        end
    endtask

    task automatic test_edges();
        logic [1:0]  cmdV  [3] = '{2'b00, 2'b11, 2'b00};
        logic [15:0] lenV  [3] = '{16'd0, 16'd4, 16'd4};
        logic [3:0]  maskV [3] = '{4'b1111, 4'b1111, 4'b0000};
        logic        errV  [3] = '{1'b0, 1'b1, 1'b1};
        for (int t = 0; t < 3; t++) begin
            clearLogs();
            startCmd(cmdV[t], 32'h500, lenV[t], maskV[t]);
            waitDone(20);
            checks++;
            if (doneQ.size() !== 1 || doneQ[0].err !== errV[t]) begin
                errors++; $display("[TB] FAIL edge%0d_done: count %0d expected 1 with err %b", t, doneQ.size(), errV[t]);
            end
            checks++;
            if (enbQ.size() !== 0 || wrQ.size() !== 0) begin
                errors++; $display("[TB] FAIL edge%0d_idle: enb %0d lane_wr %0d expected 0 0", t, enbQ.size(), wrQ.size());
            end
        end
        clearLogs();
        startCmd(2'b00, 32'hFFFF_FFFC, 16'd2, 4'b1111);
        waitDone(30);
        checks++;
        if (enbQ.size() !== 2 || enbQ[0].addr !== 32'hFFFF_FFFC || enbQ[1].addr !== 32'h0) begin
            errors++; $display("[TB] FAIL wrap_addr: count %0d expected 2 with addrb FFFFFFFC then 00000000", enbQ.size());
        end
        checks++;
        if (wrQ.size() !== 2 || wrQ[1].wr !== 4'b0010 || wrQ[1].din[32 +: 32] !== memWord(32'h0)) begin
            errors++; $display("[TB] FAIL wrap_data: count %0d expected 2 with lane 1 data %h", wrQ.size(), memWord(32'h0));
        end
        checks++;
        if (doneQ.size() !== 1 || doneQ[0].err !== 1'b0) begin errors++; $display("[TB] FAIL wrap_done: count %0d expected 1", doneQ.size()); end
    endtask

    task automatic test_back_to_back();
        clearLogs();
        startCmd(2'b00, 32'h700, 16'd4, 4'b1111);
        bus.start = 1'b1; bus.cmd = 2'b10; bus.len = 16'd2;
        @(posedge CLK); #1;
        bus.start = 1'b0;
        waitDone(40);
        checks++;
        if (enbQ.size() !== 4 || enbQ[3].web !== 4'h0 || enbQ[3].addr !== 32'h70C) begin
            errors++; $display("[TB] FAIL busy_start: enb count %0d expected 4 reads ending at 0000070c", enbQ.size());
        end
        checks++;
        if (doneQ.size() !== 1) begin errors++; $display("[TB] FAIL busy_done: got %0d expected 1", doneQ.size()); end
        clearLogs();
        startCmd(2'b00, 32'h800, 16'd1, 4'b1000);
        waitDone(30);
        checks++;
        if (wrQ.size() !== 1 || wrQ[0].wr !== 4'b1000 || wrQ[0].din[96 +: 32] !== memWord(32'h800)) begin
            errors++; $display("[TB] FAIL next_start: count %0d expected 1 write to lane 3 of %h", wrQ.size(), memWord(32'h800));
        end
    endtask

    task automatic test_reset_mid();
        clearLogs();
        startCmd(2'b00, 32'h900, 16'd8, 4'b1111);
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        RSTN = 1'b0;
        @(posedge CLK); #1;
        RSTN = 1'b1;
        @(negedge CLK);
        checks++;
        if ({bus.busy, bus.done, bus.err, bus.enb, bus.lane_wr, bus.lane_rd, bus.web} !== '0 ||
            {bus.addrb, bus.dinb, bus.lane_din} !== '0) begin
            errors++; $display("[TB] FAIL midreset_outputs: busy %b enb %b lane_wr %b addrb %h expected all 0",
                               bus.busy, bus.enb, bus.lane_wr, bus.addrb);
        end
        #1;
        checks++;
        if (enbQ.size() !== 3) begin errors++; $display("[TB] FAIL midreset_issues: got %0d expected 3", enbQ.size()); end
        repeat (8) @(negedge CLK);
        #1;
        checks++;
        if (wrQ.size() !== 0 || doneQ.size() !== 0) begin
            errors++; $display("[TB] FAIL midreset_late: lane_wr %0d done %0d expected 0 0", wrQ.size(), doneQ.size());
        end
        clearLogs();
        startCmd(2'b00, 32'h600, 16'd2, 4'b1111);
        waitDone(30);
        checks++;
        if (wrQ.size() !== 2 || wrQ[0].din[0 +: 32] !== memWord(32'h600) || wrQ[1].din[32 +: 32] !== memWord(32'h604) ||
            doneQ.size() !== 1) begin
            errors++; $display("[TB] FAIL midreset_restart: lane_wr %0d done %0d expected 2 1", wrQ.size(), doneQ.size());
        end
    endtask

    initial begin
        bus.start = 1'b0; bus.cmd = 2'b00; bus.base_addr = '0; bus.len = '0;
        bus.lane_mask = '0; bus.lane_ready = 4'b1111;
        test_reset();
        test_interleave();
        test_masked();
        test_broadcast();
        test_store();
        test_edges();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/simd_bram_sequencer.md
Name: simd_bram_sequencer

Overview:
- Parametrised load/store sequencer between one BRAM port and an array of NUM_PE processing-element lanes.
- Generalises the fixed four-PE data path to any lane count and adds a lane mask, a broadcast load mode and a configurable BRAM read latency.
- Sits between the control unit, which issues start/cmd, and the BRAM port and lane inputs/outputs.

Parameters:
NUM_PE, 4, number of PE lanes (1..32)
DATA_W, 32, lane and BRAM word width, multiple of 8
ADDR_W, 32, BRAM byte-address width
LEN_W, 16, transfer length counter width
RD_LAT, 2, BRAM read latency in cycles (1..7)

Ports:
CLK  in  1  clock
RSTN  in  1  synchronous active-low reset
start  in  1  command strobe, accepted only when idle
cmd  in  2  00 load-interleave, 01 load-broadcast, 10 store, 11 reserved
base_addr  in  ADDR_W  byte address of the first word
len  in  LEN_W  number of words to transfer
lane_mask  in  NUM_PE  enabled lanes, sampled at start
busy  out  1  high from accept until done
done  out  1  one-cycle completion pulse
err  out  1  valid with done: reserved cmd or all-zero mask
addrb  out  ADDR_W  BRAM byte address
dinb  out  DATA_W  BRAM write data
doutb  in  DATA_W  BRAM read data, RD_LAT cycles after enb
enb  out  1  BRAM enable
web  out  DATA_W/8  byte write enables, all ones or all zeros
lane_din  out  NUM_PE*DATA_W  per-lane load data; lane k is bits [k*DATA_W +: DATA_W]
lane_wr  out  NUM_PE  per-lane load strobe
lane_dout  in  NUM_PE*DATA_W  per-lane head-of-queue result
lane_rd  out  NUM_PE  per-lane pop strobe
lane_ready  in  NUM_PE  lane has results available

Behaviour:
- Reset (RSTN=0 at a CLK edge): state IDLE. busy, done, err, enb, lane_wr and lane_rd are 0. web is 0. addrb, dinb and lane_din are 0. The in-flight read pipeline is flushed. Reset mid-transfer aborts the transfer with no done pulse.
- States: IDLE, RD_ISSUE, RD_DRAIN, WR_WAIT, WR, FIN.
- IDLE with start=1: latch cmd, base_addr, len and lane_mask; set busy=1 the next cycle.
  - cmd=11 or mask=0 goes to FIN with err=1.
  - len=0 goes to FIN with err=0 and no BRAM or lane activity.
  - Otherwise loads go to RD_ISSUE and store goes to WR_WAIT.
  - start while busy is ignored.
- Address rule: word i uses addrb = base_addr + 4*i, modulo 2^ADDR_W; wrap-around is silent.
- Lane rotation: word i targets the i-th enabled lane in ascending index order, wrapping after the highest enabled lane. The rotation starts at the lowest enabled lane.
- RD_ISSUE: one read per cycle (enb=1, web=0) for len consecutive cycles. Each issue pushes {valid, target lane} into an RD_LAT-deep shift register. After the last issue, go to RD_DRAIN.
- Read return: RD_LAT cycles after an issue, the popped entry drives lane_din[target]=doutb.
  - Interleave: lane_wr is one-hot on the target lane.
  - Broadcast: every enabled lane gets doutb and lane_wr = mask; no rotation.
  - lane_din on non-strobed lanes holds its previous value.
- RD_DRAIN: wait until the shift register is empty, then go to FIN. The last lane_wr therefore occurs the cycle before done.
- WR_WAIT: wait until (lane_ready & mask) == mask, then go to WR. No timeout.
- WR: one word per cycle, len cycles; no lane_ready recheck after entry.
  - Each cycle: enb=1, web all ones, dinb = lane_dout[lane], lane_rd one-hot on that lane in the same cycle.
  - A lane presents its next result by the following cycle.
  - After the last word, go to FIN.
- FIN: done=1 and busy=0 for exactly one cycle, then IDLE. err is valid only while done=1 and reads 0 otherwise.
- enb, web and lane_rd are never asserted outside RD_ISSUE and WR.

Test Plan:
- Interleave load, base=0x100, len=8, mask=4'b1111, RD_LAT=2 -> addrb 0x100..0x11C on 8 consecutive cycles; lane k receives words k and k+4; done on the cycle after the last lane_wr.
- Masked interleave, mask=4'b1010, len=4 -> words go to lanes 1,3,1,3 in that order; lanes 0 and 2 never see lane_wr.
- Broadcast, len=2, mask=4'b0111 -> lane_wr=4'b0111 twice, each with the same doutb on lanes 0..2.
- Store, len=4, mask=1111, lane_ready held at 0111 for 5 cycles then 1111 -> no enb while waiting; then 4 writes with web=4'hF, dinb from lanes 0..3, lane_rd one-hot matching; done follows.
- Edge commands: len=0 -> done with err=0 and no enb. cmd=11 -> done with err=1. mask=0 -> done with err=1. base=0xFFFFFFFC with len=2 -> addrb 0xFFFFFFFC then 0x00000000.
- RSTN=0 in the 3rd cycle of RD_ISSUE -> next cycle all outputs 0 and no late lane_wr; a new start is accepted normally.
